tff_bank_arbiter: RTL and testbench
===================================

TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, number of T-flip-flop state bits in the bank (2..16).
REQ-002 Parameter ADDR_W, default 3, bit-select width; SHALL satisfy 2**ADDR_W >= WIDTH.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Res  input  1  reset, asynchronous, active-low.
REQ-005 Req0, Req1  input  1  per-requester command request, level, held until Ack.
REQ-006 Cmd0, Cmd1  input  2  command: 00 hold, 01 toggle bit, 10 load bit, 11 clear all.
REQ-007 Addr0, Addr1  input  ADDR_W  target bit index.
REQ-008 Din0, Din1  input  1  load value for Cmd 10.
REQ-009 Gnt0, Gnt1  output  1  grant, high while requester owns the bank.
REQ-010 Ack0, Ack1  output  1  one-cycle completion pulse.
REQ-011 Q  output  WIDTH  bank contents.
REQ-012 Busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, EXEC, ACK; one state per cycle except IDLE.
REQ-014 IDLE: no Req -> stay; any Req -> GRANT, winner chosen by round-robin pointer.
REQ-015 Round-robin: single requester always wins; both requesting -> requester not served last wins.
REQ-016 Winner's Cmd/Addr/Din SHALL be latched on the IDLE->GRANT edge; later input changes ignored.
REQ-017 Gnt of winner SHALL be high in GRANT, EXEC and ACK; at most one Gnt high, ever.
REQ-018 EXEC->ACK edge applies command: toggle inverts Q[Addr]; load writes Din to Q[Addr]; clear sets Q to 0; hold leaves Q unchanged.
REQ-019 Addr >= WIDTH: toggle/load SHALL be a no-op, still acknowledged.
REQ-020 Ack of winner SHALL be high exactly during ACK; Q already updated in that cycle.
REQ-021 Latency: Req seen in IDLE at cycle n -> Gnt at n+1, Ack at n+3, IDLE at n+4.
REQ-022 ACK->IDLE always (unless REQ-029); pointer updated to the served requester on that edge.
REQ-023 Req withdrawn before Ack: latched command SHALL still complete and Ack still pulses.
REQ-024 Req still high in IDLE after own Ack SHALL be treated as a new request.
REQ-025 Bits not addressed SHALL never change except on clear-all.

Reset
REQ-026 Res low SHALL immediately force: state IDLE, Q = 0, Gnt0/1 = 0, Ack0/1 = 0, Busy = 0, pointer favours requester 0.
REQ-027 Reset mid-operation SHALL abort the command with no Ack; after release first request starts from IDLE.
REQ-028 Release of Res SHALL not itself trigger any grant in the same cycle it deasserts.

Configuration
REQ-029 Macro TFF_BANK_ARB_LOCK_EN defined: add inputs Lock0, Lock1 (1 bit); if winner's Lock and Req high in ACK, FSM SHALL go ACK->GRANT for the same requester, latching new command, pointer unchanged.
REQ-030 Macro undefined: no Lock ports; behaviour exactly per REQ-022, no back-to-back ownership.

Verification
REQ-031 Res low, Req0=1 -> Gnt=0, Q=0; release, Req0=1 Cmd=10 Addr=2 Din=1 -> Ack0 three cycles after first IDLE sample, Q=0x04.
REQ-032 Req0 and Req1 both high from reset, Cmd=01 Addr=0/1 -> order Ack0 then Ack1, Q=0x03, Gnt never both high.
REQ-033 Req0 toggles Addr=5 twice, Req1 idle -> Q[5] 1 then 0, other bits unchanged.
REQ-034 Q=0xFF, Cmd=10 Addr=9 (WIDTH=8) -> Ack pulses, Q=0xFF; then Cmd=11 -> Q=0x00.
REQ-035 Res pulsed low during EXEC -> no Ack, Q=0, Busy=0 immediately.
REQ-036 With TFF_BANK_ARB_LOCK_EN, Lock0=1, Req0 and Req1 high -> Req0 served twice back-to-back (ACK->GRANT), Req1 waits; without macro -> alternating service.

Source files
------------

// File: rtl/tff_bank_arbiter.sv
// Two-requester arbitrated bank of T-flip-flop bits with toggle/load/clear commands.
// Optional macro TFF_BANK_ARB_LOCK_EN adds Lock0/Lock1 for back-to-back ownership.

module tff_bank_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic tog,
  input  logic ld,
  input  logic din,
  input  logic clr,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (ld)  q <= din;
    else if (tog) q <= ~q;
endmodule

module tff_bank_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Res,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [1:0]        Cmd0,
  input  logic [1:0]        Cmd1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic              Din0,
  input  logic              Din1,
`ifdef TFF_BANK_ARB_LOCK_EN
  input  logic              Lock0,
  input  logic              Lock1,
`endif
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [WIDTH-1:0]  Q,
  output logic              Busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  localparam logic [1:0] C_TOG = 2'b01;
  localparam logic [1:0] C_LD  = 2'b10;
  localparam logic [1:0] C_CLR = 2'b11;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic              din;
  } cmd_t;

  cmd_t       c0, c1, lat;
  logic [1:0] state, nxt;
  logic       owner, last, win, relock, apply;
  logic [WIDTH-1:0] tog_v, ld_v;

  assign c0 = '{cmd: Cmd0, addr: Addr0, din: Din0};
  assign c1 = '{cmd: Cmd1, addr: Addr1, din: Din1};

  // last holds the most recently served requester; reset value 1 favours requester 0
  assign win = (Req0 & Req1) ? ~last : Req1;

`ifdef TFF_BANK_ARB_LOCK_EN
  assign relock = owner ? (Lock1 & Req1) : (Lock0 & Req0);
`else
  assign relock = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (Req0 | Req1) nxt = GRANT;
      GRANT:   nxt = EXEC;
      EXEC:    nxt = ACK;
      default: nxt = relock ? GRANT : IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Res)
    if (!Res) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      lat   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && (Req0 | Req1)) begin
        owner <= win;
        lat   <= win ? c1 : c0;
      end
      if (state == ACK) begin
        if (relock) lat  <= owner ? c1 : c0;
        else        last <= owner;
      end
    end

  assign apply = (state == EXEC);

  // Out-of-range addresses match no cell, so toggle/load become no-ops
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign tog_v[i] = apply && lat.cmd == C_TOG && lat.addr == ADDR_W'(i);
    assign ld_v[i]  = apply && lat.cmd == C_LD  && lat.addr == ADDR_W'(i);
    tff_bank_cell u_cell (
      .clk  (Clk),
      .rst_n(Res),
      .tog  (tog_v[i]),
      .ld   (ld_v[i]),
      .din  (lat.din),
      .clr  (apply && lat.cmd == C_CLR),
      .q    (Q[i])
    );
  end

  assign Busy = (state != IDLE);
  assign Gnt0 = Busy & ~owner;
  assign Gnt1 = Busy &  owner;
  assign Ack0 = (state == ACK) & ~owner;
  assign Ack1 = (state == ACK) &  owner;
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Directed bench for tff_bank_arbiter (WIDTH=8, ADDR_W=4 so out-of-range addresses are reachable).

module tb_tff_bank_arbiter;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  logic Clk = 1'b0, Res = 1'b0;
  logic Req0 = 0, Req1 = 0, Din0 = 0, Din1 = 0;
  logic [1:0] Cmd0 = 0, Cmd1 = 0;
  logic [ADDR_W-1:0] Addr0 = 0, Addr1 = 0;
  logic Gnt0, Gnt1, Ack0, Ack1, Busy;
  logic [WIDTH-1:0] Q;
`ifdef TFF_BANK_ARB_LOCK_EN
  logic Lock0 = 0, Lock1 = 0;
`endif

  int n_chk = 0, n_pass = 0;

  tff_bank_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Res(Res),
    .Req0(Req0), .Req1(Req1), .Cmd0(Cmd0), .Cmd1(Cmd1),
    .Addr0(Addr0), .Addr1(Addr1), .Din0(Din0), .Din1(Din1),
`ifdef TFF_BANK_ARB_LOCK_EN
    .Lock0(Lock0), .Lock1(Lock1),
`endif
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Ack0(Ack0), .Ack1(Ack1), .Q(Q), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Issue one command from IDLE, expect Ack three edges later, then drop Req
  task automatic op(input int r, input logic [1:0] c, input logic [ADDR_W-1:0] a,
                    input logic d, input string tag);
    int cyc;
    bit got;
    if (r == 0) begin Req0 = 1; Cmd0 = c; Addr0 = a; Din0 = d; end
    else        begin Req1 = 1; Cmd1 = c; Addr1 = a; Din1 = d; end
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      tick(); cyc++;
      if ((r == 0) ? Ack0 : Ack1) got = 1;
    end
    chk({tag, "_lat"}, cyc, 3);
    Req0 = 0; Req1 = 0;
    tick();
    chk({tag, "_idle"}, {Busy, Ack0, Ack1}, 3'b000);
  endtask

  initial begin
    int cyc, nack;
    bit both;
    logic [3:0] order;
    logic [7:0] acyc [4];

    // reset holds everything low despite a pending request
    Req0 = 1; Cmd0 = 2'b10; Addr0 = 2; Din0 = 1;
    #1;
    chk("rst_imm", {Gnt0, Gnt1, Ack0, Ack1, Busy}, 5'b0);
    tick(); tick();
    chk("rst_gnt", {Gnt0, Gnt1, Busy}, 3'b000);
    chk("rst_q", Q, 8'h00);
    Res = 1; #1;
    chk("rel_nogrant", {Gnt0, Busy}, 2'b00);
    tick();
    chk("first_gnt", {Gnt0, Gnt1, Busy}, 3'b101);
    tick();
    chk("first_exec", {Ack0, Q}, 9'h000);
    tick();
    chk("first_ack", {Ack0, Ack1, Q}, {2'b10, 8'h04});
    Req0 = 0;
    tick();
    chk("first_idle", {Busy, Q}, 9'h004);

    // both requesting from reset: requester 0 first, then 1
    Res = 0; tick();
    Req0 = 1; Cmd0 = 2'b01; Addr0 = 0;
    Req1 = 1; Cmd1 = 2'b01; Addr1 = 1;
    tick(); Res = 1; #1;
    cyc = 0; nack = 0; both = 0; order = 0;
    while (nack < 2 && cyc < 40) begin
      tick(); cyc++;
      if (Gnt0 && Gnt1) both = 1;
      if (Ack0 || Ack1) begin
        order[nack] = Ack1; acyc[nack] = 8'(cyc); nack++;
        if (Ack0) Req0 = 0;
        if (Ack1) Req1 = 0;
      end
    end
    chk("both_order", {nack[1:0], order[1:0]}, {2'd2, 2'b10});
    chk("both_cyc", {acyc[0], acyc[1]}, {8'd3, 8'd7});
    chk("both_q", Q, 8'h03);
    chk("both_excl", both, 0);
    tick();

    // toggling bit 5 twice leaves other bits alone
    op(0, 2'b01, 5, 0, "tog5a");
    chk("tog5a_q", Q, 8'h23);
    op(0, 2'b01, 5, 0, "tog5b");
    chk("tog5b_q", Q, 8'h03);

    // command latched at grant; withdrawn Req and changed inputs are ignored
    Req0 = 1; Cmd0 = 2'b10; Addr0 = 4; Din0 = 1;
    tick();
    chk("latch_gnt", Gnt0, 1);
    Req0 = 0; Cmd0 = 2'b11; Addr0 = 6; Din0 = 0;
    tick(); tick();
    chk("latch_ack", {Ack0, Q}, {1'b1, 8'h13});
    tick();

    for (int i = 2; i < 8; i++) op(0, 2'b10, ADDR_W'(i), 1, "fill");
    chk("fill_q", Q, 8'hFF);
    op(0, 2'b10, 9, 0, "oor_ld");
    chk("oor_ld_q", Q, 8'hFF);
    op(0, 2'b01, 15, 0, "oor_tog");
    chk("oor_tog_q", Q, 8'hFF);
    op(0, 2'b11, 0, 0, "clr");
    chk("clr_q", Q, 8'h00);
    op(1, 2'b00, 3, 1, "hold");
    chk("hold_q", Q, 8'h00);

    // both held continuously: alternating service, last served was requester 1
    Req0 = 1; Cmd0 = 2'b01; Addr0 = 0;
    Req1 = 1; Cmd1 = 2'b01; Addr1 = 1;
    cyc = 0; nack = 0; both = 0; order = 0;
    while (nack < 4 && cyc < 60) begin
      tick(); cyc++;
      if (Gnt0 && Gnt1) both = 1;
      if (Ack0 || Ack1) begin
        order[3 - nack] = Ack1; acyc[nack] = 8'(cyc); nack++;
        if (nack == 4) begin Req0 = 0; Req1 = 0; end
      end
    end
    chk("rr_order", {nack[2:0], order}, {3'd4, 4'b0101});
    chk("rr_cyc", {acyc[0], acyc[1], acyc[2], acyc[3]}, {8'd3, 8'd7, 8'd11, 8'd15});
    chk("rr_q", Q, 8'h00);
    chk("rr_excl", both, 0);
    tick();

    // reset during EXEC aborts with no Ack
    op(0, 2'b10, 3, 1, "pre_rst");
    Req0 = 1; Cmd0 = 2'b01; Addr0 = 0;
    tick(); tick();
    chk("mid_exec", {Gnt0, Busy, Q}, {2'b11, 8'h08});
    Res = 0; #1;
    chk("mid_rst", {Ack0, Gnt0, Busy, Q}, 11'h000);
    Req0 = 0;
    tick(); Res = 1;
    tick(); tick();
    chk("post_rst", {Ack0, Busy, Q}, 10'h000);
    op(0, 2'b01, 7, 0, "post_tog");
    chk("post_tog_q", Q, 8'h80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
